// File: rtl/clksel_sequencer_if.sv
// clksel_sequencer_if: presence/lock inputs and clock-mux control outputs of the clock-source supervisor
interface clksel_sequencer_if #(
  parameter int NSRC = 3,
  parameter int SELW = 2
);
  logic [NSRC-1:0] present;
  logic            pll_locked;
  logic            force_en;
  logic [SELW-1:0] force_sel;
  logic [SELW-1:0] clkselect;
  logic            core_reset;
  logic            sel_valid;
  logic [NSRC-1:0] failed;
  logic            fault;
  logic [7:0]      switch_count;
  modport master (
    input  present, pll_locked, force_en, force_sel,
    output clkselect, core_reset, sel_valid, failed, fault, switch_count
  );
  modport slave (
    output present, pll_locked, force_en, force_sel,
    input  clkselect, core_reset, sel_valid, failed, fault, switch_count
  );
endinterface

// File: rtl/clksel_sequencer.sv
// clksel_sequencer: debounced priority clock-source selection with glitch-safe reset/switch/lock sequencing
module clksel_sequencer #(
  parameter int NSRC         = 3,
  parameter int SELW         = 2,
  parameter int DEFAULT_SRC  = 2,
  parameter int DEBOUNCE     = 1024,
  parameter int HOLD_CYC     = 64,
  parameter int SETTLE       = 256,
  parameter int LOCK_TIMEOUT = 65536
) (
  input logic rstclk,
  input logic extreset,
  clksel_sequencer_if.master bus
);
  localparam int MAXC = (LOCK_TIMEOUT > SETTLE) ? ((LOCK_TIMEOUT > HOLD_CYC) ? LOCK_TIMEOUT : HOLD_CYC)
                                                : ((SETTLE > HOLD_CYC) ? SETTLE : HOLD_CYC);
  localparam int CW = $clog2(MAXC + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [SELW-1:0] DEF = SELW'(DEFAULT_SRC);
  typedef enum logic [2:0] {ST_HOLD, ST_SWITCH, ST_SETTLE, ST_WAITLOCK, ST_RUN, ST_FAULT} state_t;
  state_t state, state_n;
  logic [NSRC-1:0] ps1, ps2, deb, deb_clr, failed, failed_n;
  logic [DW-1:0] dcnt [NSRC];
  logic lk1, lk2, fault, fault_n, core_reset, sel_valid;
  logic [CW-1:0] cnt, cnt_n;
  logic [SELW-1:0] cand, cand_n, clkselect, sel_n, target;
  logic [7:0] switch_count;
  always_ff @(posedge rstclk or posedge extreset)
    if (extreset) begin
      ps1 <= '0;
      ps2 <= '0;
      lk1 <= 1'b0;
      lk2 <= 1'b0;
      deb <= '0;
      for (int i = 0; i < NSRC; i++) dcnt[i] <= '0;
    end else begin
      ps1 <= bus.present;
      ps2 <= ps1;
      lk1 <= bus.pll_locked;
      lk2 <= lk1;
      for (int i = 0; i < NSRC; i++)
        if (i != DEFAULT_SRC && ps2[i] != deb[i]) begin
          dcnt[i] <= (dcnt[i] == DW'(DEBOUNCE - 1)) ? '0 : dcnt[i] + 1'b1;
          if (dcnt[i] == DW'(DEBOUNCE - 1)) deb[i] <= ps2[i];
        end else dcnt[i] <= '0;
    end
  // a debounced unplug wipes that source's failure history
  always_comb begin
    deb_clr = '0;
    for (int i = 0; i < NSRC; i++)
      deb_clr[i] = (i != DEFAULT_SRC) && deb[i] && !ps2[i] && dcnt[i] == DW'(DEBOUNCE - 1);
  end
  always_comb begin
    target = DEF;
    for (int i = NSRC - 1; i >= 0; i--)
      target = ((i == DEFAULT_SRC || deb[i]) && !failed[i]) ? SELW'(i) : target;
    target = !bus.force_en ? target : (32'(bus.force_sel) < NSRC ? bus.force_sel : DEF);
  end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    cand_n   = cand;
    sel_n    = clkselect;
    fault_n  = fault;
    failed_n = failed & ~deb_clr;
    case (state)
      ST_HOLD: if (cnt == CW'(HOLD_CYC - 1)) begin
        state_n = ST_SWITCH;
        cnt_n   = '0;
      end
      ST_SWITCH: begin
        sel_n   = cand;
        state_n = ST_SETTLE;
        cnt_n   = '0;
      end
      ST_SETTLE: if (cnt == CW'(SETTLE - 1)) begin
        state_n = ST_WAITLOCK;
        cnt_n   = '0;
      end
      ST_WAITLOCK:
        if (lk2) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          cnt_n = '0;
          for (int i = 0; i < NSRC; i++) if (cand == SELW'(i)) failed_n[i] = 1'b1;
          state_n = (cand == DEF) ? ST_FAULT : ST_HOLD;
          fault_n = fault | (cand == DEF);
          cand_n  = DEF;
        end
      // lock loss relocks the current source and outranks a target change
      ST_RUN: begin
        cnt_n = '0;
        if (!lk2) state_n = ST_HOLD;
        else if (target != clkselect) begin
          state_n = ST_HOLD;
          cand_n  = target;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_FAULT;
        sel_n   = DEF;
      end
    endcase
  end
  always_ff @(posedge rstclk or posedge extreset)
    if (extreset) begin
      state        <= ST_SETTLE;
      cnt          <= '0;
      cand         <= DEF;
      clkselect    <= DEF;
      core_reset   <= 1'b1;
      sel_valid    <= 1'b0;
      failed       <= '0;
      fault        <= 1'b0;
      switch_count <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      cand         <= cand_n;
      clkselect    <= sel_n;
      core_reset   <= state_n != ST_RUN;
      sel_valid    <= state_n == ST_RUN;
      failed       <= failed_n;
      fault        <= fault_n;
      switch_count <= switch_count + {7'd0, state != ST_RUN && state_n == ST_RUN};
    end
  assign bus.clkselect    = clkselect;
  assign bus.core_reset   = core_reset;
  assign bus.sel_valid    = sel_valid;
  assign bus.failed       = failed;
  assign bus.fault        = fault;
  assign bus.switch_count = switch_count;
endmodule

// File: tb/tb_clksel_sequencer.sv
// tb_clksel_sequencer: randomized scenario bench for clksel_sequencer against a source-priority reference model
module tb_clksel_sequencer;
  localparam int NSRC = 3, SELW = 2, DEF = 2, DEB = 4, HOLD = 4, SET = 8, TO = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int m_count = 0;
  logic [NSRC-1:0] m_present = '0;
  logic [NSRC-1:0] m_failed = '0;
  logic [SELW-1:0] prev_sel = '0;
  logic prev_cr = 1'b1;
  logic prev_ok = 1'b0;
  always #5 clk = ~clk;
  clksel_sequencer_if #(.NSRC(NSRC), .SELW(SELW)) bus ();
  clksel_sequencer #(
    .NSRC(NSRC), .SELW(SELW), .DEFAULT_SRC(DEF), .DEBOUNCE(DEB),
    .HOLD_CYC(HOLD), .SETTLE(SET), .LOCK_TIMEOUT(TO)
  ) dut (
    .rstclk(clk),
    .extreset(rst),
    .bus(bus)
  );
  // the mux select may only move while the core is held in reset
  always @(negedge clk) begin
    if (!rst && prev_ok) begin
      n_cmp++;
      if (bus.clkselect !== prev_sel && !(prev_cr && bus.core_reset)) begin
        n_bad++;
        $display("FAIL sel_while_running: clkselect %0d -> %0d, core_reset %0b -> %0b, required core_reset 1 -> 1",
                 prev_sel, bus.clkselect, prev_cr, bus.core_reset);
      end
    end
    prev_ok = !rst;
    prev_sel = bus.clkselect;
    prev_cr = bus.core_reset;
  end
  function automatic logic [SELW-1:0] m_target(input logic fe, input logic [SELW-1:0] fs);
    if (fe) return (int'(fs) < NSRC) ? fs : SELW'(DEF);
    for (int i = 0; i < NSRC; i++) if ((i == DEF || m_present[i]) && !m_failed[i]) return SELW'(i);
    return SELW'(DEF);
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    int k;
    rst = 1'b1;
    bus.present = '0;
    bus.pll_locked = 1'b1;
    bus.force_en = 1'b0;
    bus.force_sel = '0;
    cyc(3);
    n_cmp++; if (bus.clkselect !== SELW'(DEF)) begin n_bad++; $display("FAIL reset_clkselect: got %0d expected %0d", bus.clkselect, DEF); end
    n_cmp++; if (bus.core_reset !== 1'b1 || bus.sel_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl: got core_reset=%0b sel_valid=%0b expected 1/0", bus.core_reset, bus.sel_valid); end
    n_cmp++; if (bus.failed !== '0 || bus.fault !== 1'b0) begin n_bad++; $display("FAIL reset_failed: got failed=%b fault=%0b expected 0/0", bus.failed, bus.fault); end
    n_cmp++; if (bus.switch_count !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", bus.switch_count); end
    rst = 1'b0;
    k = -1;
    for (int i = 1; i <= 20 && k < 0; i++) begin
      @(negedge clk);
      if (!bus.core_reset) k = i;
    end
    m_count = 1;
    n_cmp++; if (k != SET + 1) begin n_bad++; $display("FAIL reset_release_cycle: got %0d expected %0d", k, SET + 1); end
    n_cmp++; if (bus.switch_count !== 8'(m_count) || bus.sel_valid !== 1'b1) begin n_bad++; $display("FAIL reset_run: got count=%0d sel_valid=%0b expected %0d/1", bus.switch_count, bus.sel_valid, m_count); end
  endtask
  task automatic test_priority;
    int s, rise, sel, fall;
    logic [SELW-1:0] exp;
    s = $urandom_range(0, 1);
    for (int ph = 0; ph < 2; ph++) begin
      bus.present[s] = (ph == 0);
      m_present[s] = (ph == 0);
      exp = m_target(1'b0, '0);
      rise = -1; sel = -1; fall = -1;
      for (int k = 1; k <= 60 && fall < 0; k++) begin
        @(negedge clk);
        if (rise < 0 && bus.core_reset) rise = k;
        if (sel < 0 && bus.clkselect == exp) sel = k;
        if (sel > 0 && fall < 0 && !bus.core_reset) fall = k;
      end
      m_count++;
      n_cmp++; if (rise != 3 + DEB) begin n_bad++; $display("FAIL prio_hold_entry: got %0d expected %0d", rise, 3 + DEB); end
      n_cmp++; if (sel != 4 + DEB + HOLD) begin n_bad++; $display("FAIL prio_sel_change: got %0d expected %0d", sel, 4 + DEB + HOLD); end
      n_cmp++; if (fall != 5 + DEB + HOLD + SET) begin n_bad++; $display("FAIL prio_release: got %0d expected %0d", fall, 5 + DEB + HOLD + SET); end
      n_cmp++; if (bus.switch_count !== 8'(m_count)) begin n_bad++; $display("FAIL prio_count: got %0d expected %0d", bus.switch_count, m_count); end
    end
  endtask
  task automatic test_lock_fail;
    int s, sel, fk;
    logic dropped, ok;
    s = $urandom_range(0, 1);
    bus.present[s] = 1'b1;
    m_present[s] = 1'b1;
    sel = -1; fk = -1; dropped = 1'b0;
    for (int k = 1; k <= 120 && fk < 0; k++) begin
      @(negedge clk);
      if (!dropped && bus.core_reset) begin bus.pll_locked = 1'b0; dropped = 1'b1; end
      if (sel < 0 && bus.clkselect == SELW'(s)) sel = k;
      if (fk < 0 && bus.failed[s]) fk = k;
    end
    bus.pll_locked = 1'b1;
    m_failed[s] = 1'b1;
    n_cmp++; if (fk != 4 + DEB + HOLD + SET + TO) begin n_bad++; $display("FAIL lockfail_timeout: got %0d expected %0d", fk, 4 + DEB + HOLD + SET + TO); end
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin @(negedge clk); ok = bus.sel_valid; end
    m_count++;
    n_cmp++; if (bus.clkselect !== m_target(1'b0, '0) || !ok) begin n_bad++; $display("FAIL lockfail_fallback: got sel=%0d valid=%0b expected %0d/1", bus.clkselect, ok, m_target(1'b0, '0)); end
    n_cmp++; if (bus.failed !== m_failed) begin n_bad++; $display("FAIL lockfail_mask: got %b expected %b", bus.failed, m_failed); end
    n_cmp++; if (bus.switch_count !== 8'(m_count)) begin n_bad++; $display("FAIL lockfail_count: got %0d expected %0d", bus.switch_count, m_count); end
    bus.present[s] = 1'b0;
    m_present[s] = 1'b0;
    cyc(1 + DEB);
    n_cmp++; if (bus.failed !== m_failed) begin n_bad++; $display("FAIL unplug_early: got %b expected %b", bus.failed, m_failed); end
    cyc(1);
    m_failed[s] = 1'b0;
    n_cmp++; if (bus.failed !== m_failed) begin n_bad++; $display("FAIL unplug_clear: got %b expected %b", bus.failed, m_failed); end
    n_cmp++; if (bus.clkselect !== SELW'(DEF) || bus.sel_valid !== 1'b1) begin n_bad++; $display("FAIL unplug_run: got sel=%0d valid=%0b expected %0d/1", bus.clkselect, bus.sel_valid, DEF); end
  endtask
  task automatic test_bounce;
    int changed;
    logic [SELW-1:0] s0;
    changed = 0;
    cyc($urandom_range(0, 2));
    s0 = bus.clkselect;
    for (int k = 0; k < 60 + DEB + 6; k++) begin
      if (k < 60 && k % 3 == 0) bus.present[1] = ~bus.present[1];
      if (k == 60) bus.present[1] = 1'b0;
      @(negedge clk);
      if (bus.clkselect !== s0 || bus.core_reset !== 1'b0) changed++;
    end
    n_cmp++; if (changed != 0) begin n_bad++; $display("FAIL bounce_stable: got %0d disturbed cycles expected 0", changed); end
    n_cmp++; if (bus.switch_count !== 8'(m_count)) begin n_bad++; $display("FAIL bounce_count: got %0d expected %0d", bus.switch_count, m_count); end
  endtask
  task automatic test_lock_loss;
    int rk;
    logic ok;
    rk = -1;
    bus.pll_locked = 1'b0;
    for (int k = 1; k <= 8 && rk < 0; k++) begin
      @(negedge clk);
      if (bus.core_reset) rk = k;
    end
    n_cmp++; if (rk < 1 || rk > 4) begin n_bad++; $display("FAIL lockloss_latency: got %0d expected 1..4", rk); end
    n_cmp++; if (bus.clkselect !== SELW'(DEF)) begin n_bad++; $display("FAIL lockloss_sel: got %0d expected %0d", bus.clkselect, DEF); end
    cyc($urandom_range(1, 10));
    bus.pll_locked = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin @(negedge clk); ok = bus.sel_valid; end
    m_count++;
    n_cmp++; if (!ok || bus.clkselect !== SELW'(DEF)) begin n_bad++; $display("FAIL relock_run: got valid=%0b sel=%0d expected 1/%0d", ok, bus.clkselect, DEF); end
    n_cmp++; if (bus.switch_count !== 8'(m_count)) begin n_bad++; $display("FAIL relock_count: got %0d expected %0d", bus.switch_count, m_count); end
  endtask
  task automatic test_force;
    int v;
    logic fe, ok;
    logic [SELW-1:0] exp;
    for (int it = 0; it < 7; it++) begin
      v = (it == 0) ? 3 : int'($urandom_range(0, 3));
      fe = (it < 6);
      bus.force_en = fe;
      bus.force_sel = SELW'(v);
      exp = m_target(fe, SELW'(v));
      if (exp != bus.clkselect) begin
        ok = 1'b0;
        for (int k = 0; k < 150 && !ok; k++) begin @(negedge clk); ok = bus.sel_valid && bus.clkselect == exp; end
        m_count++;
      end else cyc(10);
      n_cmp++; if (bus.clkselect !== exp || bus.sel_valid !== 1'b1) begin n_bad++; $display("FAIL force_sel_%0d: got sel=%0d valid=%0b expected %0d/1", v, bus.clkselect, bus.sel_valid, exp); end
      n_cmp++; if (bus.switch_count !== 8'(m_count)) begin n_bad++; $display("FAIL force_count_%0d: got %0d expected %0d", v, bus.switch_count, m_count); end
    end
  endtask
  task automatic test_fault;
    logic ok;
    logic [NSRC-1:0] exp_failed;
    exp_failed = m_failed;
    exp_failed[DEF] = 1'b1;
    bus.pll_locked = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin @(negedge clk); ok = bus.fault; end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fault_set: got 0 expected 1"); end
    n_cmp++; if (bus.failed !== exp_failed) begin n_bad++; $display("FAIL fault_mask: got %b expected %b", bus.failed, exp_failed); end
    n_cmp++; if (bus.clkselect !== SELW'(DEF) || bus.sel_valid !== 1'b0) begin n_bad++; $display("FAIL fault_outputs: got sel=%0d valid=%0b expected %0d/0", bus.clkselect, bus.sel_valid, DEF); end
    bus.pll_locked = 1'b1;
    cyc(40);
    n_cmp++; if (bus.fault !== 1'b1 || bus.core_reset !== 1'b1) begin n_bad++; $display("FAIL fault_sticky: got fault=%0b core_reset=%0b expected 1/1", bus.fault, bus.core_reset); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.fault !== 1'b0 || bus.failed !== '0 || bus.switch_count !== 8'd0) begin n_bad++; $display("FAIL fault_async_clear: got fault=%0b failed=%b count=%0d expected 0/0/0", bus.fault, bus.failed, bus.switch_count); end
    @(negedge clk);
    rst = 1'b0;
    m_failed = '0;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin @(negedge clk); ok = bus.sel_valid; end
    m_count = 1;
    n_cmp++; if (!ok || bus.switch_count !== 8'(m_count) || bus.clkselect !== SELW'(DEF)) begin n_bad++; $display("FAIL fault_recover: got valid=%0b count=%0d sel=%0d expected 1/%0d/%0d", ok, bus.switch_count, bus.clkselect, m_count, DEF); end
  endtask
  initial begin
    test_reset();
    test_priority();
    test_lock_fail();
    test_bounce();
    test_lock_loss();
    test_force();
    test_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
